// File: rtl/lights_pkg.sv
// -----------------------------------------------------------------------------
// lights_pkg
// Shared definitions for the multi-channel lights selector:
//   - mode_e      : front-panel operating mode (OFF / WHITE / MANUAL / AUTO)
//   - COL_*       : colour indices of the 6-entry palette (1..6)
//   - next_colour : advance rule, 1 -> 2 -> ... -> 6 -> 1
// No ports (package).
// -----------------------------------------------------------------------------
package lights_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_WHITE  = 2'b01,
        MODE_MANUAL = 2'b10,
        MODE_AUTO   = 2'b11
    } mode_e;

    localparam logic [2:0] COL_BLUE    = 3'd1;
    localparam logic [2:0] COL_GREEN   = 3'd2;
    localparam logic [2:0] COL_CYAN    = 3'd3;
    localparam logic [2:0] COL_RED     = 3'd4;
    localparam logic [2:0] COL_MAGENTA = 3'd5;
    localparam logic [2:0] COL_YELLOW  = 3'd6;
    localparam logic [2:0] COL_FIRST   = 3'd1;
    localparam logic [2:0] COL_LAST    = 3'd6;

    // Advance one palette step. Indices 0 and 7 are never stored; should one
    // ever appear (e.g. an upset), it is steered back onto the palette.
    function automatic logic [2:0] next_colour(input logic [2:0] idx);
        logic [2:0] nxt;
        if ((idx >= COL_LAST) || (idx < COL_FIRST)) begin
            nxt = COL_FIRST;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/colour_expand.sv
// -----------------------------------------------------------------------------
// colour_expand
// Maps a 3-bit palette index onto one RGB word: each index bit is replicated
// across a full colour component, giving {R,G,B} = {idx[2],idx[1],idx[0]}
// each spread over CW bits.
// Ports:
//   idx  in   3       palette index (1..6 in normal use)
//   rgb  out  3*CW    {R,G,B} word
// -----------------------------------------------------------------------------
module colour_expand #(
    parameter int CW = 8
) (
    input  logic [2:0]      idx,
    output logic [3*CW-1:0] rgb
);

    assign rgb = {{CW{idx[2]}}, {CW{idx[1]}}, {CW{idx[0]}}};

endmodule

// File: rtl/lights_selector_multi.sv
// -----------------------------------------------------------------------------
// lights_selector_multi
// N_CH lamp channels, each holding a palette index. In MANUAL mode a button
// press (rising edge) advances the channel chosen by ch_sel; in AUTO mode an
// internal timer advances every channel once per AUTO_DIV cycles. OFF and
// WHITE override the outputs while the indices are held.
// Ports:
//   clk      in   1             rising-edge clock
//   rst      in   1             asynchronous reset, active low
//   mode     in   2             00 OFF, 01 WHITE, 10 MANUAL, 11 AUTO
//   ch_sel   in   SW            channel advanced by the button in MANUAL
//   button   in   1             level input, synchronous to clk
//   light    out  N_CH*3*CW     registered; channel k at [k*3*CW +: 3*CW]
//   cur_idx  out  3             registered index of channel ch_sel (0 if none)
//   tick     out  1             registered one-cycle pulse per auto step
// -----------------------------------------------------------------------------
module lights_selector_multi
    import lights_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CW       = 8,
    parameter int AUTO_DIV = 16,
    localparam int SW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [SW-1:0]          ch_sel,
    input  logic                   button,
    output logic [N_CH*3*CW-1:0]   light,
    output logic [2:0]             cur_idx,
    output logic                   tick
);

    localparam int              WW         = 3 * CW;
    localparam int              TW         = $clog2(AUTO_DIV);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(AUTO_DIV - 1);
    localparam int              NSEL       = 2 ** SW;

    mode_e                 mode_s;
    logic                  press_s;
    logic                  auto_step_s;
    logic                  btn_q;
    logic [TW-1:0]         timer_q;
    logic [TW-1:0]         timer_d;
    logic [2:0]            idx_q [N_CH];
    logic [2:0]            idx_d [N_CH];
    logic [2:0]            sel_tab_s [NSEL];
    logic [N_CH*WW-1:0]    pal_s;
    logic [N_CH*WW-1:0]    light_q;
    logic [N_CH*WW-1:0]    light_d;
    logic [2:0]            cur_idx_q;
    logic [2:0]            cur_idx_d;
    logic                  tick_q;
    logic                  tick_d;

    assign mode_s = mode_e'(mode);

    // Palette expansion of every stored index.
    for (genvar g = 0; g < N_CH; g++) begin : g_pal
        colour_expand #(.CW(CW)) u_colour_expand (
            .idx (idx_q[g]),
            .rgb (pal_s[g*WW +: WW])
        );
    end

    // Index lookup padded to the full ch_sel range; unused selector codes
    // read back as 0 so an out-of-range ch_sel reports "no channel".
    for (genvar g = 0; g < NSEL; g++) begin : g_sel
        if (g < N_CH) begin : g_real
            assign sel_tab_s[g] = idx_q[g];
        end else begin : g_none
            assign sel_tab_s[g] = 3'd0;
        end
    end

    // Next state of the auto timer and the colour indices, driven by mode.
    always_comb begin
        press_s     = button & ~btn_q;
        auto_step_s = 1'b0;
        timer_d     = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx_d[k] = idx_q[k];
        end
        case (mode_s)
            MODE_MANUAL: begin
                // An out-of-range ch_sel matches no channel, so the press is lost.
                for (int k = 0; k < N_CH; k++) begin
                    idx_d[k] = (press_s && (ch_sel == SW'(k))) ? next_colour(idx_q[k])
                                                               : idx_q[k];
                end
            end
            MODE_AUTO: begin
                if (timer_q == TIMER_LAST) begin
                    auto_step_s = 1'b1;
                    timer_d     = '0;
                    for (int k = 0; k < N_CH; k++) begin
                        idx_d[k] = next_colour(idx_q[k]);
                    end
                end else begin
                    auto_step_s = 1'b0;
                    timer_d     = timer_q + TW'(1);
                end
            end
            default: begin
                // OFF / WHITE: indices hold, timer is cleared.
                auto_step_s = 1'b0;
                timer_d     = '0;
            end
        endcase
    end

    // Output words computed from the indices as they stand before this edge,
    // which gives the one-cycle index-to-light latency.
    always_comb begin
        light_d   = '0;
        cur_idx_d = sel_tab_s[ch_sel];
        tick_d    = auto_step_s;
        case (mode_s)
            MODE_OFF:   light_d = '0;
            MODE_WHITE: light_d = '1;
            default:    light_d = pal_s;
        endcase
    end

    // State registers: edge detector, timer and channel indices.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q   <= 1'b0;
            timer_q <= '0;
            for (int k = 0; k < N_CH; k++) begin
                idx_q[k] <= COL_FIRST;
            end
        end else begin
            btn_q   <= button;
            timer_q <= timer_d;
            for (int k = 0; k < N_CH; k++) begin
                idx_q[k] <= idx_d[k];
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            light_q   <= '1;
            cur_idx_q <= COL_FIRST;
            tick_q    <= 1'b0;
        end else begin
            light_q   <= light_d;
            cur_idx_q <= cur_idx_d;
            tick_q    <= tick_d;
        end
    end

    assign light   = light_q;
    assign cur_idx = cur_idx_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_lights_selector_multi.sv
module tb_lights_selector_multi;
    import lights_pkg::*;

    localparam int N_CH     = 4;
    localparam int CW       = 8;
    localparam int AUTO_DIV = 16;

    localparam logic [23:0] CB = 24'h0000FF;
    localparam logic [23:0] CG = 24'h00FF00;
    localparam logic [23:0] CC = 24'h00FFFF;
    localparam logic [95:0] ONES = {96{1'b1}};

    logic        clk = 1'b0;
    logic        rst_s;
    logic [1:0]  mode_s;
    logic [1:0]  ch_sel_s;
    logic [1:0]  ch_sel3_s;
    logic        button_s;
    logic [95:0] light_s;
    logic [2:0]  cur_idx_s;
    logic        tick_s;
    logic [71:0] light3_s;
    logic [2:0]  cur3_s;
    logic        tick3_s;

    always #5 clk = ~clk;

    lights_selector_multi #(.N_CH(N_CH), .CW(CW), .AUTO_DIV(AUTO_DIV)) dut (
        .clk(clk), .rst(rst_s), .mode(mode_s), .ch_sel(ch_sel_s), .button(button_s),
        .light(light_s), .cur_idx(cur_idx_s), .tick(tick_s)
    );

    lights_selector_multi #(.N_CH(3), .CW(CW), .AUTO_DIV(AUTO_DIV)) dut3 (
        .clk(clk), .rst(rst_s), .mode(mode_s), .ch_sel(ch_sel3_s), .button(button_s),
        .light(light3_s), .cur_idx(cur3_s), .tick(tick3_s)
    );

    // Reference model: colour names per index, counts of consecutive AUTO edges.
    logic [23:0] pal_tab [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                                 24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'h000000};
    int          m_idx [N_CH];
    bit          m_btn;
    int          m_run;
    logic [95:0] exp_light;
    logic [2:0]  exp_cur;
    logic        exp_tick;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  md;
        logic [1:0]  cs;
        logic        b;
        logic [95:0] light;
        logic [2:0]  cur;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) m_idx[k] = 1;
        m_btn     = 1'b0;
        m_run     = 0;
        exp_light = ONES;
        exp_cur   = 3'd1;
        exp_tick  = 1'b0;
    endtask

    task automatic model_edge();
        int sel;
        sel = int'(ch_sel_s);
        case (mode_s)
            MODE_OFF:   exp_light = '0;
            MODE_WHITE: exp_light = ONES;
            default: for (int k = 0; k < N_CH; k++) exp_light[k*24 +: 24] = pal_tab[m_idx[k]];
        endcase
        exp_cur  = (sel < N_CH) ? 3'(m_idx[sel]) : 3'd0;
        m_run    = (mode_s == MODE_AUTO) ? m_run + 1 : 0;
        exp_tick = (mode_s == MODE_AUTO) && ((m_run % AUTO_DIV) == 0);
        if ((mode_s == MODE_MANUAL) && button_s && !m_btn && (sel < N_CH))
            m_idx[sel] = m_idx[sel] % 6 + 1;
        if (exp_tick)
            for (int k = 0; k < N_CH; k++) m_idx[k] = m_idx[k] % 6 + 1;
        m_btn = button_s;
    endtask

    // Called just after a falling edge: drive, take one rising edge, compare.
    task automatic step(input logic [1:0] md, input logic [1:0] cs, input logic b);
        mode_s   = md;
        ch_sel_s = cs;
        button_s = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model_light", light_s, exp_light);
        check("model_cur_idx", {93'd0, cur_idx_s}, {93'd0, exp_cur});
        check("model_tick", {95'd0, tick_s}, {95'd0, exp_tick});
    endtask

    task automatic do_reset();
        rst_s = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        check("rst_light", light_s, ONES);
        check("rst_cur_idx", {93'd0, cur_idx_s}, 96'd1);
        check("rst_tick", {95'd0, tick_s}, 96'd0);
        rst_s = 1'b1;
    endtask

    initial begin
        int ticks;
        logic [1:0] rmode;

        vecs[0]  = '{MODE_WHITE,  2'd0, 1'b0, ONES,            3'd1};
        vecs[1]  = '{MODE_MANUAL, 2'd2, 1'b0, {CB, CB, CB, CB}, 3'd1};
        vecs[2]  = '{MODE_MANUAL, 2'd2, 1'b1, {CB, CB, CB, CB}, 3'd1};
        vecs[3]  = '{MODE_MANUAL, 2'd2, 1'b0, {CB, CG, CB, CB}, 3'd2};
        vecs[4]  = '{MODE_MANUAL, 2'd2, 1'b0, {CB, CG, CB, CB}, 3'd2};
        vecs[5]  = '{MODE_MANUAL, 2'd1, 1'b1, {CB, CG, CB, CB}, 3'd1};
        vecs[6]  = '{MODE_MANUAL, 2'd1, 1'b1, {CB, CG, CG, CB}, 3'd2};
        vecs[7]  = '{MODE_MANUAL, 2'd1, 1'b0, {CB, CG, CG, CB}, 3'd2};
        vecs[8]  = '{MODE_OFF,    2'd1, 1'b1, 96'd0,            3'd2};
        vecs[9]  = '{MODE_MANUAL, 2'd1, 1'b1, {CB, CG, CG, CB}, 3'd2};
        vecs[10] = '{MODE_WHITE,  2'd3, 1'b0, ONES,            3'd1};
        vecs[11] = '{MODE_MANUAL, 2'd3, 1'b1, {CB, CG, CG, CB}, 3'd1};
        vecs[12] = '{MODE_MANUAL, 2'd3, 1'b0, {CG, CG, CG, CB}, 3'd2};

        rst_s     = 1'b0;
        mode_s    = MODE_WHITE;
        ch_sel_s  = 2'd0;
        ch_sel3_s = 2'd3;
        button_s  = 1'b0;
        @(negedge clk);

        // Table-driven vectors from reset.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].md, vecs[i].cs, vecs[i].b);
            check($sformatf("vec%0d_light", i), light_s, vecs[i].light);
            check($sformatf("vec%0d_cur_idx", i), {93'd0, cur_idx_s}, {93'd0, vecs[i].cur});
            check($sformatf("vec%0d_tick", i), {95'd0, tick_s}, 96'd0);
        end

        // Six separate presses on channel 0 walk the whole palette and wrap.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(MODE_MANUAL, 2'd0, 1'b1);
            step(MODE_MANUAL, 2'd0, 1'b0);
            check($sformatf("press_seq%0d", i), {93'd0, cur_idx_s}, 96'((i + 1) % 6 + 1));
        end
        check("wrap_ch0_blue", {72'd0, light_s[23:0]}, {72'd0, CB});

        // A button held for 20 cycles is a single press.
        for (int i = 0; i < 20; i++) step(MODE_MANUAL, 2'd0, 1'b1);
        step(MODE_MANUAL, 2'd0, 1'b0);
        check("held_one_step", {93'd0, cur_idx_s}, 96'd2);

        // Three-channel instance: ch_sel=3 addresses no channel.
        do_reset();
        ch_sel3_s = 2'd3;
        step(MODE_MANUAL, 2'd0, 1'b1);
        step(MODE_MANUAL, 2'd0, 1'b0);
        check("n3_cur_idx_oob", {93'd0, cur3_s}, 96'd0);
        check("n3_light_unchanged", {24'd0, light3_s}, {24'd0, CB, CB, CB});
        ch_sel3_s = 2'd2;
        step(MODE_MANUAL, 2'd0, 1'b0);
        check("n3_cur_idx_ch2", {93'd0, cur3_s}, 96'd1);
        ch_sel3_s = 2'd3;

        // OFF blanks the lamps but keeps the colours.
        step(MODE_OFF, 2'd0, 1'b0);
        check("off_dark", light_s, 96'd0);
        step(MODE_MANUAL, 2'd0, 1'b0);
        check("off_restore", light_s, {CB, CB, CB, CG});

        // AUTO from reset, with button activity that must be ignored.
        do_reset();
        ticks = 0;
        for (int i = 0; i < 48; i++) begin
            step(MODE_AUTO, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if (tick_s) ticks++;
            if (i == 15) check("auto_first_tick", {95'd0, tick_s}, 96'd1);
        end
        check("auto_tick_count", 96'(ticks), 96'd3);
        check("auto_light_cyan", light_s, {CC, CC, CC, CC});

        // Leaving AUTO on the terminal-count edge suppresses that step.
        do_reset();
        for (int i = 0; i < 15; i++) step(MODE_AUTO, 2'd0, 1'b0);
        step(MODE_MANUAL, 2'd0, 1'b0);
        check("swap_no_tick", {95'd0, tick_s}, 96'd0);
        step(MODE_MANUAL, 2'd0, 1'b0);
        check("swap_no_step", light_s, {CB, CB, CB, CB});
        for (int i = 0; i < 16; i++) step(MODE_AUTO, 2'd0, 1'b0);
        check("reenter_tick_16", {95'd0, tick_s}, 96'd1);

        // Asynchronous reset between edges, right while tick is high.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(MODE_AUTO, 2'd1, 1'b0);
            if (tick_s) break;
        end
        check("async_pre_tick", {95'd0, tick_s}, 96'd1);
        #2 rst_s = 1'b0;
        #1;
        check("async_light", light_s, ONES);
        check("async_tick", {95'd0, tick_s}, 96'd0);
        check("async_cur_idx", {93'd0, cur_idx_s}, 96'd1);
        model_reset();
        @(negedge clk);
        rst_s = 1'b1;
        for (int i = 0; i < 16; i++) step(MODE_AUTO, 2'd1, 1'b0);

        // Randomised run with sticky modes so AUTO gets long stretches.
        rmode = MODE_MANUAL;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) rmode = 2'($urandom_range(0, 3));
            step(rmode, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
